// File: rtl/mips_main_control_if.sv
// Control bus between the multicycle MIPS main control FSM and the datapath.
// The master side is the controller and the slave side is the datapath.
interface mips_main_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       memReady;
  logic       iOrD;
  logic       irWrite;
  logic       memWrite;
  logic       regDst;
  logic       memtoReg;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] pcSrc;
  logic       pcEn;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, zero, memReady,
    output iOrD, irWrite, memWrite, regDst, memtoReg, regWrite,
           aluSrcA, aluSrcB, aluOp, pcSrc, pcEn, illegal, state
  );

  modport slave (
    output opcode, zero, memReady,
    input  iOrD, irWrite, memWrite, regDst, memtoReg, regWrite,
           aluSrcA, aluSrcB, aluOp, pcSrc, pcEn, illegal, state
  );
endinterface

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback
// and Moore-decodes the datapath controls from the current state.
module mips_main_control #(
  parameter bit ENABLE_BNE  = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  mips_main_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     cur_state;
  logic       illegal_q;
  state_t     decode_next;
  logic       decode_ok;
  logic       is_bne;

  logic       i_or_d, ir_write, mem_write, reg_dst, memto_reg, reg_write;
  logic       alu_src_a, pc_en;
  logic [1:0] alu_src_b, alu_op, pc_src;

  // Opcode dispatch; disabled optional instructions fall into the illegal path.
  always_comb begin
    decode_next = FETCH;
    decode_ok   = 1'b1;
    case (bus.opcode)
      OP_RTYPE:     decode_next = EXECUTE;
      OP_LW, OP_SW: decode_next = MEMADR;
      OP_BEQ:       decode_next = BRANCH;
      OP_BNE: begin
        if (ENABLE_BNE) decode_next = BRANCH;
        else            decode_ok   = 1'b0;
      end
      OP_ADDI:      decode_next = ADDIEXEC;
      OP_J: begin
        if (ENABLE_JUMP) decode_next = JUMP;
        else             decode_ok   = 1'b0;
      end
      default:      decode_ok = 1'b0;
    endcase
  end

  assign is_bne = ENABLE_BNE && (bus.opcode == OP_BNE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (cur_state)
        FETCH:    cur_state <= bus.memReady ? DECODE : FETCH;
        DECODE: begin
          cur_state <= decode_next;
          if (!decode_ok) illegal_q <= 1'b1;
        end
        MEMADR:   cur_state <= (bus.opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:    cur_state <= bus.memReady ? MEMWB : MEMRD;
        MEMWB:    cur_state <= FETCH;
        MEMWR:    cur_state <= bus.memReady ? FETCH : MEMWR;
        EXECUTE:  cur_state <= ALUWB;
        ALUWB:    cur_state <= FETCH;
        BRANCH:   cur_state <= FETCH;
        ADDIEXEC: cur_state <= ADDIWB;
        ADDIWB:   cur_state <= FETCH;
        JUMP:     cur_state <= FETCH;
        default:  cur_state <= FETCH;
      endcase
    end
  end

  // Write-type strobes are suppressed during reset so an aborted instruction
  // cannot commit anything.
  always_comb begin
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_dst   = 1'b0;
    memto_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    pc_src    = 2'b00;
    pc_en     = 1'b0;
    case (cur_state)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = bus.memReady;
        pc_en     = bus.memReady;
      end
      DECODE:   alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD:    i_or_d = 1'b1;
      MEMWB: begin
        memto_reg = 1'b1;
        reg_write = 1'b1;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = is_bne ? ~bus.zero : bus.zero;
      end
      ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB:   reg_write = 1'b1;
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      pc_en     = 1'b0;
    end
  end

  assign bus.iOrD     = i_or_d;
  assign bus.irWrite  = ir_write;
  assign bus.memWrite = mem_write;
  assign bus.regDst   = reg_dst;
  assign bus.memtoReg = memto_reg;
  assign bus.regWrite = reg_write;
  assign bus.aluSrcA  = alu_src_a;
  assign bus.aluSrcB  = alu_src_b;
  assign bus.aluOp    = alu_op;
  assign bus.pcSrc    = pc_src;
  assign bus.pcEn     = pc_en;
  assign bus.illegal  = illegal_q;
  assign bus.state    = cur_state;

endmodule

// File: doc/mips_main_control.md
Name: mips_main_control

Overview:
- Multicycle MIPS main control FSM. It sequences each instruction through fetch, decode, execute, memory and writeback.
- It generates the datapath enables and muxes, and produces the 2-bit aluOp consumed by the ALU control decoder.
- It sits between the instruction register opcode field and the datapath. One instruction completes per FSM loop back to FETCH.

Parameters:
- ENABLE_BNE, 1, when 1 opcode 000101 is decoded as bne (inverted branch condition); when 0 it is illegal.
- ENABLE_JUMP, 1, when 1 opcode 000010 is decoded as j; when 0 it is illegal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register; stable from DECODE until return to FETCH.
- zero  in  1  ALU zero flag.
- memReady  in  1  memory access complete this cycle.
- iOrD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irWrite  out  1  instruction register load.
- memWrite  out  1  memory write strobe.
- regDst  out  1  destination register: 0 = rt, 1 = rd.
- memtoReg  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- regWrite  out  1  register file write.
- aluSrcA  out  1  0 = PC, 1 = rs.
- aluSrcB  out  2  00 = rt, 01 = const 4, 10 = signext imm, 11 = signext imm << 2.
- aluOp  out  2  00 = add, 01 = sub, 10 = use funct.
- pcSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcEn  out  1  PC load.
- illegal  out  1  sticky flag: an unknown opcode was decoded.
- state  out  4  current state, for debug.

Behaviour:
- State register is 4 bits. Encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11
  - Codes 12-15 go to FETCH on the next edge; all outputs 0 while in them.
- Reset: at the edge with reset=1, state <= FETCH and illegal <= 0. Reset mid-instruction aborts the instruction; no partial write occurs after the edge.
- While reset=1, irWrite, memWrite, regWrite and pcEn are forced to 0.
- All outputs except illegal and state are Moore-decoded from state. The exceptions are the memReady gating and the pcEn equation below.
- Unlisted outputs are 0 in every state.
- FETCH:
  - iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00.
  - irWrite = pcEn = memReady.
  - Next state: memReady ? DECODE : FETCH.
- DECODE:
  - aluSrcA=0, aluSrcB=11, aluOp=00 (branch target computed into ALUOut).
  - Next state by opcode:
    - 000000 -> EXECUTE
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000100 (beq) -> BRANCH
    - 000101 (bne) -> BRANCH
    - 001000 (addi) -> ADDIEXEC
    - 000010 (j) -> JUMP
    - anything else -> FETCH, and illegal <= 1.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iOrD=1. Next: memReady ? MEMWB : MEMRD.
- MEMWB: memtoReg=1, regDst=0, regWrite=1. Next: FETCH.
- MEMWR: iOrD=1, memWrite=1 (held every wait cycle). Next: memReady ? FETCH : MEMWR.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10. Next: ALUWB.
- ALUWB: regDst=1, memtoReg=0, regWrite=1. Next: FETCH.
- BRANCH:
  - aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01.
  - beq: pcEn = zero. bne: pcEn = ~zero.
  - Next: FETCH.
- ADDIEXEC: aluSrcA=1, aluSrcB=10, aluOp=00. Next: ADDIWB.
- ADDIWB: regDst=0, memtoReg=0, regWrite=1. Next: FETCH.
- JUMP: pcSrc=10, pcEn=1. Next: FETCH.
- Instruction latency with memReady=1 throughout:
  - lw 5 cycles; sw, R-type and addi 4; beq, bne and j 3.
  - Each memReady=0 cycle in FETCH, MEMRD or MEMWR adds 1 cycle.
- illegal stays 1 until reset. Fetch and decode continue normally after an illegal opcode.
- Outputs carry no X values: every state drives defined values.

Test Plan:
- Reset held 2 cycles, then released with memReady=1 -> state=0, irWrite=1 and pcEn=1 only after reset deasserts; illegal=0.
- opcode=100011, memReady=1 -> states 0,1,2,3,4,0. In MEMADR aluSrcB=10. In MEMWB regWrite=1 and memtoReg=1.
- opcode=101011, memReady=0 for 3 MEMWR cycles then 1 -> memWrite=1 for all 4 MEMWR cycles; next state FETCH; regWrite never 1.
- opcode=000000 -> states 0,1,6,7,0. In EXECUTE aluOp=10. In ALUWB regDst=1.
- Branches:
  - opcode=000100, zero=1 -> pcEn=1 in BRANCH.
  - opcode=000100, zero=0 -> pcEn=0.
  - opcode=000101, zero=0 -> pcEn=1; aluOp=01 in all three cases.
- Illegal opcode and mid-instruction reset:
  - opcode=111111 -> DECODE goes to FETCH and illegal=1, which persists.
  - Reset asserted during MEMWR -> state=0, memWrite=0, illegal=0 next cycle.
